// File: rtl/id_ex_skid.sv
// ID->EX pipeline register with a valid/ready handshake, an optional 2-entry
// skid buffer, flush, and a saturating counter of EX back-pressure cycles.
// SKID=1: id_ready comes from a flop. SKID=0: a single entry, and id_ready
// is combinational from ex_ready.
module id_ex_skid #(
  parameter int XLEN     = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int RADDR_W  = 5,
  parameter int SKID     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [XLEN-1:0]     id_reg1,
  input  logic [XLEN-1:0]     id_reg2,
  input  logic [RADDR_W-1:0]  id_wd,
  input  logic                id_wreg,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [XLEN-1:0]     id_imm,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [XLEN-1:0]     ex_reg1,
  output logic [XLEN-1:0]     ex_reg2,
  output logic [RADDR_W-1:0]  ex_wd,
  output logic                ex_wreg,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_imm,
  input  logic                stall_clr,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam int PW = ALUOP_W + ALUSEL_W + 4*XLEN + RADDR_W + 1;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   out_q, out_d;
  logic [PW-1:0]   skid_q, skid_d;
  logic [PW-1:0]   id_pl;
  logic            ready_q, ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            out_wreg;
  logic            up_beat, dn_beat;

  assign id_pl = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg, id_pc, id_imm};

  assign ex_valid = (state_q != ST_EMPTY);
  // With SKID=0 there is no room to absorb an op, so we accept only when the
  // output slot drains this cycle. With SKID=1 the skid slot takes that role.
  assign id_ready = rst & ((SKID != 0) ? ready_q : (!ex_valid | ex_ready));
  assign up_beat  = id_valid & id_ready;
  assign dn_beat  = ex_valid & ex_ready;

  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, out_wreg, ex_pc, ex_imm} = out_q;
  // A stale write enable must never escape while the slot is empty.
  assign ex_wreg   = ex_valid & out_wreg;
  assign stall_cnt = cnt_q;

  // Next-state logic for occupancy, the output slot, the skid slot and the counter.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (up_beat) begin
          state_d = ST_FULL;
          out_d   = id_pl;
        end
      end
      ST_FULL: begin
        if (up_beat && dn_beat) begin
          out_d = id_pl;
        end else if (up_beat) begin
          state_d = ST_SKID;
          skid_d  = id_pl;
        end else if (dn_beat) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (dn_beat) begin
          state_d = ST_FULL;
          out_d   = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A flush drops everything, including an op accepted this cycle. The
    // payload stays stale because ex_valid/ex_wreg already mask it.
    if (flush) begin
      state_d = ST_EMPTY;
      out_d   = out_q;
      skid_d  = skid_q;
    end

    ready_d = (state_d != ST_SKID);

    cnt_d = cnt_q;
    if (stall_clr) begin
      cnt_d = '0;
    end else if (ex_valid && !ex_ready && !flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    if (!rst) begin
      state_q <= ST_EMPTY;
      // NOTE: the payload flops are reset as well. There are only two slots, and this gives a defined ex_* value after reset.
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid. It builds one instance with SKID=1 and one with
// SKID=0, both with CNT_W=4. Each instance runs a table of hand-computed
// vectors, and a few hand-written sequences follow.
module tb_id_ex_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        flush     [2];
  logic        id_valid  [2];
  logic        id_ready  [2];
  logic [7:0]  id_aluop  [2];
  logic [2:0]  id_alusel [2];
  logic [31:0] id_reg1   [2];
  logic [31:0] id_reg2   [2];
  logic [4:0]  id_wd     [2];
  logic        id_wreg   [2];
  logic [31:0] id_pc     [2];
  logic [31:0] id_imm    [2];
  logic        ex_valid  [2];
  logic        ex_ready  [2];
  logic [7:0]  ex_aluop  [2];
  logic [2:0]  ex_alusel [2];
  logic [31:0] ex_reg1   [2];
  logic [31:0] ex_reg2   [2];
  logic [4:0]  ex_wd     [2];
  logic        ex_wreg   [2];
  logic [31:0] ex_pc     [2];
  logic [31:0] ex_imm    [2];
  logic        stall_clr [2];
  logic [3:0]  stall_cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    id_ex_skid #(.SKID(g), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst[g]), .flush(flush[g]),
      .id_valid(id_valid[g]), .id_ready(id_ready[g]),
      .id_aluop(id_aluop[g]), .id_alusel(id_alusel[g]),
      .id_reg1(id_reg1[g]), .id_reg2(id_reg2[g]), .id_wd(id_wd[g]),
      .id_wreg(id_wreg[g]), .id_pc(id_pc[g]), .id_imm(id_imm[g]),
      .ex_valid(ex_valid[g]), .ex_ready(ex_ready[g]),
      .ex_aluop(ex_aluop[g]), .ex_alusel(ex_alusel[g]),
      .ex_reg1(ex_reg1[g]), .ex_reg2(ex_reg2[g]), .ex_wd(ex_wd[g]),
      .ex_wreg(ex_wreg[g]), .ex_pc(ex_pc[g]), .ex_imm(ex_imm[g]),
      .stall_clr(stall_clr[g]), .stall_cnt(stall_cnt[g])
    );
  end

  // Each payload field is derived from pc, so every op carries a distinct, checkable payload.
  function automatic logic [7:0]  f_aluop (input logic [31:0] pc); return pc[9:2] ^ 8'hC3;      endfunction
  function automatic logic [2:0]  f_alusel(input logic [31:0] pc); return pc[4:2];              endfunction
  function automatic logic [31:0] f_reg1  (input logic [31:0] pc); return ~pc;                  endfunction
  function automatic logic [31:0] f_reg2  (input logic [31:0] pc); return pc + 32'h100;         endfunction
  function automatic logic [4:0]  f_wd    (input logic [31:0] pc); return pc[6:2];              endfunction
  function automatic logic [31:0] f_imm   (input logic [31:0] pc); return pc ^ 32'hA5A5_0000;   endfunction

  typedef struct {
    int          d;
    logic        rst, flush, idv, wreg, exr, clr;
    logic [31:0] pc;
    logic        ev, er, ew;
    logic [31:0] epc;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic add(input int d, input logic r, fl, v, input logic [31:0] pc,
                     input logic w, er_in, cl, input logic ev, er, input logic [31:0] epc,
                     input logic ew, input int ecnt);
    vec_t e;
    e.d = d; e.rst = r; e.flush = fl; e.idv = v; e.pc = pc; e.wreg = w;
    e.exr = er_in; e.clr = cl; e.ev = ev; e.er = er; e.epc = epc; e.ew = ew;
    e.ecnt = 4'(ecnt);
    tbl.push_back(e);
  endtask

  task automatic drive(input int d, input logic r, fl, v, input logic [31:0] pc,
                       input logic w, er, cl);
    rst[d] = r; flush[d] = fl; id_valid[d] = v; id_pc[d] = pc; id_wreg[d] = w;
    ex_ready[d] = er; stall_clr[d] = cl;
    id_aluop[d] = f_aluop(pc); id_alusel[d] = f_alusel(pc); id_reg1[d] = f_reg1(pc);
    id_reg2[d] = f_reg2(pc); id_wd[d] = f_wd(pc); id_imm[d] = f_imm(pc);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Build the vector table for one instance. s=1 selects the skid variant.
  task automatic build(input int d);
    logic s;
    int   cf;
    s  = (d == 1);
    cf = s ? 5 : 4;
    // Reset held for 3 cycles while decode offers an op, then released.
    for (int i = 0; i < 3; i++) add(d, 0,0,1,'h40,1,0,0, 0,0,'h0,0,0);
    add(d, 1,0,0,'h0,0,1,0, 0,1,'h0,0,0);
    // Back-to-back stream with ex_ready=1.
    add(d, 1,0,1,'h0,1,1,0, 1,1,'h0,1,0);
    add(d, 1,0,1,'h4,0,1,0, 1,1,'h4,0,0);
    add(d, 1,0,1,'h8,1,1,0, 1,1,'h8,1,0);
    add(d, 1,0,0,'h0,0,1,0, 0,1,'h8,0,0);
    // Stall: A is held. B goes to skid (SKID=1) or waits upstream (SKID=0).
    add(d, 1,0,1,'h10,1,0,0, 1,s,'h10,1,0);
    add(d, 1,0,1,'h14,0,0,0, 1,0,'h10,1,1);
    for (int k = 2; k <= 4; k++) add(d, 1,0,!s,'h14,0,0,0, 1,0,'h10,1,k);
    add(d, 1,0,!s,'h14,0,1,0, 1,1,'h14,0,4);
    add(d, 1,0,0,'h0,0,1,0, 0,1,'h14,0,4);
    // Flush with C offered while held (SKID state for SKID=1).
    add(d, 1,0,1,'h20,1,0,0, 1,s,'h20,1,4);
    if (s) add(d, 1,0,1,'h24,1,0,0, 1,0,'h20,1,5);
    add(d, 1,1,1,'h18,1,0,0, 0,1,'h20,0,cf);
    add(d, 1,0,0,'h0,0,1,0, 0,1,'h20,0,cf);
    // Flush together with a downstream beat and an upstream beat. The new op is dropped.
    add(d, 1,0,1,'h30,1,0,0, 1,s,'h30,1,cf);
    add(d, 1,1,1,'h34,1,1,0, 0,1,'h30,0,cf);
    add(d, 1,0,0,'h0,0,1,0, 0,1,'h30,0,cf);
    // Counter clear, 20 stall cycles saturating at 15, then clear while stalled.
    add(d, 1,0,0,'h0,0,1,1, 0,1,'h30,0,0);
    add(d, 1,0,1,'h50,1,0,0, 1,s,'h50,1,0);
    for (int i = 0; i < 20; i++) add(d, 1,0,0,'h0,0,0,0, 1,s,'h50,1,(i+1 > 15) ? 15 : i+1);
    add(d, 1,0,0,'h0,0,0,1, 1,s,'h50,1,0);
    add(d, 1,0,0,'h0,0,1,0, 0,1,'h50,0,0);
  endtask

  initial begin
    int lat;
    drive(0, 0,0,0,'h0,0,0,0);
    drive(1, 0,0,0,'h0,0,0,0);
    build(1);
    build(0);

    for (int k = 0; k < tbl.size(); k++) begin
      int d;
      d = tbl[k].d;
      drive(d, tbl[k].rst, tbl[k].flush, tbl[k].idv, tbl[k].pc, tbl[k].wreg, tbl[k].exr, tbl[k].clr);
      @(posedge clk); #1;
      check($sformatf("d%0d row%0d ex_valid", d, k), 32'(ex_valid[d]), 32'(tbl[k].ev));
      check($sformatf("d%0d row%0d id_ready", d, k), 32'(id_ready[d]), 32'(tbl[k].er));
      check($sformatf("d%0d row%0d ex_pc", d, k), ex_pc[d], tbl[k].epc);
      check($sformatf("d%0d row%0d ex_wreg", d, k), 32'(ex_wreg[d]), 32'(tbl[k].ew));
      check($sformatf("d%0d row%0d stall_cnt", d, k), 32'(stall_cnt[d]), 32'(tbl[k].ecnt));
      if (tbl[k].ev) begin
        check($sformatf("d%0d row%0d ex_aluop", d, k), 32'(ex_aluop[d]), 32'(f_aluop(tbl[k].epc)));
        check($sformatf("d%0d row%0d ex_alusel", d, k), 32'(ex_alusel[d]), 32'(f_alusel(tbl[k].epc)));
        check($sformatf("d%0d row%0d ex_reg1", d, k), ex_reg1[d], f_reg1(tbl[k].epc));
        check($sformatf("d%0d row%0d ex_reg2", d, k), ex_reg2[d], f_reg2(tbl[k].epc));
        check($sformatf("d%0d row%0d ex_wd", d, k), 32'(ex_wd[d]), 32'(f_wd(tbl[k].epc)));
        check($sformatf("d%0d row%0d ex_imm", d, k), ex_imm[d], f_imm(tbl[k].epc));
      end
    end

    // SKID=0: while FULL, id_ready follows ex_ready within the same cycle.
    drive(0, 1,0,1,'h60,1,0,0);
    @(posedge clk); #1;
    check("d0 comb full ex_valid", 32'(ex_valid[0]), 32'd1);
    check("d0 comb ready low", 32'(id_ready[0]), 32'd0);
    drive(0, 1,0,0,'h0,0,1,0);
    #1;
    check("d0 comb ready follows ex_ready", 32'(id_ready[0]), 32'd1);
    @(posedge clk); #1;
    check("d0 comb drained", 32'(ex_valid[0]), 32'd0);

    // SKID=1: an op accepted at an edge must show ex_valid one cycle later (bounded wait).
    drive(1, 1,0,1,'h70,1,1,0);
    @(posedge clk); #1;
    drive(1, 1,0,0,'h0,0,1,0);
    lat = 1;
    while (!ex_valid[1] && lat < 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("d1 accept latency", 32'(lat), 32'd1);
    check("d1 latency ex_pc", ex_pc[1], 32'h70);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
